// File: rtl/plane_cache_loader.sv
// Loads one HUB75 row pair from the RGB frame RAM, extracts a single bit-plane
// per colour and writes WIDTH 6-bit words into the line cache.
module plane_cache_loader #(
    parameter int WIDTH      = 64,
    parameter int HALF_ROWS  = 16,
    parameter int COLOR_BITS = 8,
    parameter int ADDR_W     = 11,
    parameter int COL_W      = 6,
    parameter int ROW_W      = 4,
    parameter int PLANE_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_CACHE,
    input  logic [ROW_W-1:0]        in_ROW,
    input  logic [PLANE_W-1:0]      in_PLANE,
    output logic                    out_MEM_RD,
    output logic [ADDR_W-1:0]       out_MEM_ADDR,
    input  logic [3*COLOR_BITS-1:0] in_MEM_DATA,
    output logic                    out_CACHE_WE,
    output logic [COL_W-1:0]        out_CACHE_WADDR,
    output logic [5:0]              out_CACHE_WDATA,
    output logic                    out_BUSY,
    output logic                    out_PLANE_READY_MM
);

    typedef enum logic [2:0] {IDLE, RD_UP, RD_LO, CAP, DONE} state_t;

    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] HALF_A  = ADDR_W'(HALF_ROWS);

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [PLANE_W-1:0]   plane_q;
    logic [2:0]           upper_q;

    logic [COLOR_BITS-1:0] r_ch, g_ch, b_ch;
    logic [2:0]            plane_bits;
    logic                  last_col;
    logic [ADDR_W-1:0]     upper_addr, lower_addr;

    assign r_ch       = in_MEM_DATA[3*COLOR_BITS-1:2*COLOR_BITS];
    assign g_ch       = in_MEM_DATA[2*COLOR_BITS-1:COLOR_BITS];
    assign b_ch       = in_MEM_DATA[COLOR_BITS-1:0];
    assign plane_bits = {r_ch[plane_q], g_ch[plane_q], b_ch[plane_q]};
    assign last_col   = (col_q == COL_W'(WIDTH - 1));
    assign upper_addr = ADDR_W'(row_q) * WIDTH_A + ADDR_W'(col_q);
    assign lower_addr = (ADDR_W'(row_q) + HALF_A) * WIDTH_A + ADDR_W'(col_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            upper_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_CACHE) begin
                        col_q   <= '0;
                        row_q   <= in_ROW;
                        plane_q <= in_PLANE;
                    end
                end
                RD_LO: upper_q <= plane_bits;
                CAP: begin
                    if (!last_col) begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_CACHE) state_d = RD_UP;
            RD_UP:   state_d = RD_LO;
            RD_LO:   state_d = CAP;
            CAP:     state_d = last_col ? DONE : RD_UP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lower-row bits go to the cache straight from the RAM data bus in CAP.
    always_comb begin
        out_MEM_RD         = 1'b0;
        out_MEM_ADDR       = '0;
        out_CACHE_WE       = 1'b0;
        out_CACHE_WADDR    = '0;
        out_CACHE_WDATA    = '0;
        out_PLANE_READY_MM = 1'b0;
        out_BUSY           = (state_q != IDLE);
        case (state_q)
            RD_UP: begin
                out_MEM_RD   = 1'b1;
                out_MEM_ADDR = upper_addr;
            end
            RD_LO: begin
                out_MEM_RD   = 1'b1;
                out_MEM_ADDR = lower_addr;
            end
            CAP: begin
                out_CACHE_WE    = 1'b1;
                out_CACHE_WADDR = col_q;
                out_CACHE_WDATA = {upper_q, plane_bits};
            end
            DONE:    out_PLANE_READY_MM = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_plane_cache_loader.sv
// Self-checking bench for plane_cache_loader: table of load scenarios, per-cycle
// expected handshake plus a scoreboard of expected cache writes.
module tb_plane_cache_loader;

    localparam int WIDTH = 64;
    localparam int HALF  = 16;
    localparam int CB    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_CACHE;
    logic [3:0]  in_ROW;
    logic [2:0]  in_PLANE;
    logic        out_MEM_RD;
    logic [10:0] out_MEM_ADDR;
    logic [23:0] in_MEM_DATA;
    logic        out_CACHE_WE;
    logic [5:0]  out_CACHE_WADDR;
    logic [5:0]  out_CACHE_WDATA;
    logic        out_BUSY;
    logic        out_PLANE_READY_MM;

    plane_cache_loader #(
        .WIDTH(WIDTH), .HALF_ROWS(HALF), .COLOR_BITS(CB),
        .ADDR_W(11), .COL_W(6), .ROW_W(4), .PLANE_W(3)
    ) dut (
        .clk(clk), .rst(rst), .in_CACHE(in_CACHE), .in_ROW(in_ROW), .in_PLANE(in_PLANE),
        .out_MEM_RD(out_MEM_RD), .out_MEM_ADDR(out_MEM_ADDR), .in_MEM_DATA(in_MEM_DATA),
        .out_CACHE_WE(out_CACHE_WE), .out_CACHE_WADDR(out_CACHE_WADDR),
        .out_CACHE_WDATA(out_CACHE_WDATA), .out_BUSY(out_BUSY),
        .out_PLANE_READY_MM(out_PLANE_READY_MM)
    );

    always #5 clk = ~clk;

    // Frame RAM: synchronous read, data valid the cycle after the read enable.
    logic [23:0] ram [0:2047];
    always @(posedge clk) begin
        if (out_MEM_RD) in_MEM_DATA <= ram[out_MEM_ADDR];
    end

    typedef struct {
        int row;
        int plane;
        int frame;
        int pulse_a;
        int pulse_b;
        int abort_at;
        int exp_ready;
        int exp_writes;
    } vec_t;

    typedef struct {
        logic [5:0] waddr;
        logic [5:0] wdata;
    } wr_t;

    wr_t  sb[$];
    vec_t vecs[14];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({out_BUSY, out_MEM_RD, out_CACHE_WE, out_PLANE_READY_MM,
                    out_MEM_ADDR, out_CACHE_WADDR, out_CACHE_WDATA});
    endfunction

    task automatic fill(input int frame);
        for (int a = 0; a < 2048; a++) begin
            if (frame == 0)
                ram[a] = {8'(a % 64), ~8'(a % 64), 8'((a / 64) * 4)};
            else
                ram[a] = 24'($urandom);
        end
    endtask

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic run(input vec_t v);
        int          ready_at;
        int          nwr;
        int          ph;
        int          col;
        logic [23:0] u, l;
        logic        e_rd, e_we, e_rdy, e_busy;
        logic [10:0] e_addr;
        wr_t         e;
        ready_at = 0;
        nwr      = 0;
        sb.delete();
        for (int c = 0; c < WIDTH; c++) begin
            u = ram[v.row * WIDTH + c];
            l = ram[(v.row + HALF) * WIDTH + c];
            sb.push_back('{6'(c), {u[16 + v.plane], u[8 + v.plane], u[v.plane],
                                   l[16 + v.plane], l[8 + v.plane], l[v.plane]}});
        end
        in_ROW   = 4'(v.row);
        in_PLANE = 3'(v.plane);
        in_CACHE = 1'b1;
        for (int k = 1; k <= 3 * WIDTH + 2; k++) begin
            @(negedge clk);
            in_CACHE = (k == v.pulse_a) || (k == v.pulse_b);
            in_ROW   = 4'($urandom);
            in_PLANE = 3'($urandom);
            if (k == v.abort_at) begin
                rst = 1'b0;
                #1;
                check("abort_outputs", all_outs(), 32'd0);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("abort_hold", all_outs(), 32'd0);
                end
                rst      = 1'b1;
                in_CACHE = 1'b0;
                break;
            end
            ph     = (k - 1) % 3;
            col    = (k - 1) / 3;
            e_rd   = (k <= 3 * WIDTH) && (ph < 2);
            e_we   = (k <= 3 * WIDTH) && (ph == 2);
            e_rdy  = (k == 3 * WIDTH + 1);
            e_busy = (k <= 3 * WIDTH + 1);
            e_addr = (ph == 0) ? 11'(v.row * WIDTH + col) : 11'((v.row + HALF) * WIDTH + col);
            check("cycle",
                  {out_BUSY, out_MEM_RD, out_CACHE_WE, out_PLANE_READY_MM,
                   e_rd ? out_MEM_ADDR : 11'd0, e_we ? out_CACHE_WADDR : 6'd0},
                  {e_busy, e_rd, e_we, e_rdy, e_rd ? e_addr : 11'd0, e_we ? 6'(col) : 6'd0});
            if (out_CACHE_WE) begin
                nwr++;
                if (sb.size() == 0) begin
                    check("sb_extra_write", 32'(out_CACHE_WADDR), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("wdata", {out_CACHE_WADDR, out_CACHE_WDATA}, {e.waddr, e.wdata});
                end
            end
            if (out_PLANE_READY_MM) ready_at = (ready_at == 0) ? k : -1;
        end
        check("write_count", 32'(nwr), 32'(v.exp_writes));
        check("ready_cycle", 32'(ready_at), 32'(v.exp_ready));
    endtask

    initial begin
        rst      = 1'b0;
        in_CACHE = 1'b0;
        in_ROW   = '0;
        in_PLANE = '0;
        in_MEM_DATA = '0;

        //            row plane frm pa  pb   abort ready writes
        vecs[0]  = '{  3, 0, 0,   0,   0,   0, 193, 64};
        for (int p = 0; p < 8; p++)
            vecs[1 + p] = '{5, p, 1, 0, 0, 0, 193, 64};
        vecs[9]  = '{  7, 2, 1,  50, 193,   0, 193, 64};
        vecs[10] = '{  2, 5, 1,   0,   0,   0, 193, 64};
        vecs[11] = '{  9, 1, 1,   0,   0, 100,   0, 33};
        vecs[12] = '{  1, 7, 0,   0,   0,   0, 193, 64};
        vecs[13] = '{ 15, 4, 1,   0,   0,   0, 193, 64};

        // Reset held: requests must produce no activity.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("reset_outputs", all_outs(), 32'd0);
            in_CACHE = ~in_CACHE;
        end
        @(negedge clk);
        in_CACHE = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_reset", all_outs(), 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            if (i == 0 || vecs[i].frame != vecs[i - 1].frame || vecs[i].frame == 1)
                fill(vecs[i].frame);
            run(vecs[i]);
        end

        @(negedge clk);
        check("final_idle", all_outs(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
